// File: rtl/keypad_lock_pkg.sv
// ============================================================================
// keypad_lock_pkg : shared key codes, FSM states and 7-segment glyphs
// Rev 1.0
// ============================================================================
`default_nettype none

package keypad_lock_pkg;

    localparam int CODE_LEN = 3;

    typedef logic [3:0] digit_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SET   = 2'd1,
        ST_INPUT = 2'd2
    } lock_state_e;

    localparam digit_t KEY_0 = 4'h0;
    localparam digit_t KEY_1 = 4'h1;
    localparam digit_t KEY_2 = 4'h2;
    localparam digit_t KEY_3 = 4'h3;
    localparam digit_t KEY_4 = 4'h4;
    localparam digit_t KEY_5 = 4'h5;
    localparam digit_t KEY_6 = 4'h6;
    localparam digit_t KEY_7 = 4'h7;
    localparam digit_t KEY_8 = 4'h8;
    localparam digit_t KEY_9 = 4'h9;
    localparam digit_t KEY_A = 4'hA;
    localparam digit_t KEY_B = 4'hB;
    localparam digit_t KEY_C = 4'hC;
    localparam digit_t KEY_D = 4'hD;
    localparam digit_t KEY_E = 4'hE;
    localparam digit_t KEY_F = 4'hF;

    // Segment order {a,b,c,d,e,f,g,dp}, active-low
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_S     = 8'h49;
    localparam logic [7:0] SEG_I     = 8'hF3;

    function automatic digit_t key_lookup(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'b1100: return KEY_1;
            4'b1101: return KEY_2;
            4'b1110: return KEY_3;
            4'b1111: return KEY_A;
            4'b1000: return KEY_4;
            4'b1001: return KEY_5;
            4'b1010: return KEY_6;
            4'b1011: return KEY_B;
            4'b0100: return KEY_7;
            4'b0101: return KEY_8;
            4'b0110: return KEY_9;
            4'b0111: return KEY_C;
            4'b0000: return KEY_E;
            4'b0001: return KEY_0;
            4'b0010: return KEY_F;
            default: return KEY_D;
        endcase
    endfunction

    function automatic logic [7:0] hex_glyph(input digit_t d);
        case (d)
            4'h0: return 8'h03;
            4'h1: return 8'h9F;
            4'h2: return 8'h25;
            4'h3: return 8'h0D;
            4'h4: return 8'h99;
            4'h5: return 8'h49;
            4'h6: return 8'h41;
            4'h7: return 8'h1F;
            4'h8: return 8'h01;
            4'h9: return 8'h09;
            4'hA: return 8'h11;
            4'hB: return 8'hC1;
            4'hC: return 8'h63;
            4'hD: return 8'h85;
            4'hE: return 8'h61;
            default: return 8'h71;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_scan.sv
// ============================================================================
// keypad_scan : 4x4 keypad column scanner with per-key press edge detection
// Rev 1.0
// ============================================================================
`default_nettype none

module keypad_scan
    import keypad_lock_pkg::*;
#(
    parameter int unsigned CNT_THRESHOLD = 100000
) (
    input  logic       clk,
    input  logic       rst_ni,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic       tick_o,
    output logic       key_valid_o,
    output digit_t     key_code_o
);

    logic [31:0] cnt_q;
    logic [3:0]  col_q;
    logic [1:0]  col_idx_q;
    logic [3:0]  pressed_q [4];
    logic        key_valid_q;
    digit_t      key_code_q;

    logic        w_tick;
    logic [3:0]  w_new;
    logic [1:0]  w_row_sel;

    assign w_tick = (cnt_q == CNT_THRESHOLD);

    // Newly pressed rows in the active column; the lowest row index wins
    always_comb begin
        w_new     = ~row_i & ~pressed_q[col_idx_q];
        w_row_sel = 2'd3;
        if (w_new[0])      w_row_sel = 2'd0;
        else if (w_new[1]) w_row_sel = 2'd1;
        else if (w_new[2]) w_row_sel = 2'd2;
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q       <= '0;
            col_q       <= 4'b1110;
            col_idx_q   <= 2'd0;
            pressed_q   <= '{default: 4'b0000};
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
        end else begin
            key_valid_q <= 1'b0;
            if (w_tick) begin
                cnt_q                <= '0;
                col_q                <= {col_q[2:0], col_q[3]};
                col_idx_q            <= col_idx_q + 2'd1;
                pressed_q[col_idx_q] <= ~row_i;
                if (|w_new) begin
                    key_valid_q <= 1'b1;
                    key_code_q  <= key_lookup(w_row_sel, col_idx_q);
                end
            end else begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    assign col_o       = col_q;
    assign tick_o      = w_tick;
    assign key_valid_o = key_valid_q;
    assign key_code_o  = key_code_q;

endmodule

`default_nettype wire

// File: rtl/keypad_lock.sv
// ============================================================================
// keypad_lock : 3-digit keypad combination lock with LED and 7-segment status
// Rev 1.0
// ============================================================================
`default_nettype none

module keypad_lock
    import keypad_lock_pkg::*;
#(
    parameter int unsigned CNT_THRESHOLD = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       set_code_button,
    input  logic       confirm_button,
    input  logic       input_button,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [2:0] red_led,
    output logic [2:0] gre_led,
    output logic [7:0] led_cx,
    output logic [7:0] led_en
);

    logic        w_tick;
    logic        w_key_valid;
    digit_t      w_key_code;

    keypad_scan #(
        .CNT_THRESHOLD (CNT_THRESHOLD)
    ) u_scan (
        .clk         (clk),
        .rst_ni      (reset),
        .row_i       (row),
        .col_o       (col),
        .tick_o      (w_tick),
        .key_valid_o (w_key_valid),
        .key_code_o  (w_key_code)
    );

    logic [2:0]                  btn_q;
    lock_state_e                 state_q;
    logic [CODE_LEN-1:0][3:0]    buf_q;
    logic [CODE_LEN-1:0][3:0]    code_q;
    logic [1:0]                  num_q;
    logic [1:0]                  fail_q;
    logic [2:0]                  red_q;
    logic [2:0]                  gre_q;
    logic [2:0]                  dig_q;
    logic [7:0]                  led_en_q;
    logic [7:0]                  led_cx_q;

    logic                        w_set_edge;
    logic                        w_input_edge;
    logic                        w_confirm_edge;
    lock_state_e                 w_state_mid;
    logic                        w_clear;
    logic                        w_confirm_set;
    logic                        w_confirm_in;
    logic                        w_match;
    logic [CODE_LEN-1:0][3:0]    w_buf_base;
    logic [1:0]                  w_num_base;
    logic [1:0]                  w_fail_inc;
    logic [7:0]                  w_glyph;

    assign w_set_edge     = set_code_button & ~btn_q[2];
    assign w_input_edge   = input_button    & ~btn_q[1];
    assign w_confirm_edge = confirm_button  & ~btn_q[0];

    // Button effect comes first; a same-cycle key then lands in w_state_mid
    always_comb begin
        w_state_mid   = state_q;
        w_clear       = 1'b0;
        w_confirm_set = 1'b0;
        w_confirm_in  = 1'b0;
        if (w_set_edge) begin
            w_state_mid = ST_SET;
            w_clear     = 1'b1;
        end else if (w_input_edge) begin
            if (state_q != ST_SET) begin
                w_state_mid = ST_INPUT;
                w_clear     = 1'b1;
            end
        end else if (w_confirm_edge) begin
            if (state_q == ST_SET) begin
                w_confirm_set = 1'b1;
                w_state_mid   = ST_IDLE;
            end else if (state_q == ST_INPUT) begin
                w_confirm_in = 1'b1;
                w_state_mid  = ST_IDLE;
            end
        end
    end

    assign w_match    = (num_q == 2'(CODE_LEN)) && (buf_q == code_q);
    assign w_buf_base = w_clear ? '0 : buf_q;
    assign w_num_base = w_clear ? 2'd0 : num_q;
    assign w_fail_inc = (fail_q == 2'd3) ? 2'd3 : fail_q + 2'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_q   <= '0;
            state_q <= ST_IDLE;
            buf_q   <= '0;
            code_q  <= '0;
            num_q   <= '0;
            fail_q  <= '0;
            red_q   <= '0;
            gre_q   <= '0;
        end else begin
            btn_q   <= {set_code_button, input_button, confirm_button};
            state_q <= w_state_mid;
            if (w_clear) begin
                buf_q <= '0;
                num_q <= '0;
                gre_q <= '0;
            end
            if (w_confirm_set && (num_q == 2'(CODE_LEN))) begin
                code_q <= buf_q;
            end
            if (w_confirm_in) begin
                if (w_match) begin
                    gre_q  <= 3'b111;
                    red_q  <= 3'b000;
                    fail_q <= 2'd0;
                end else begin
                    gre_q  <= 3'b000;
                    fail_q <= w_fail_inc;
                    red_q  <= {w_fail_inc == 2'd3, w_fail_inc >= 2'd2, w_fail_inc >= 2'd1};
                end
            end
            if (w_key_valid && (w_state_mid != ST_IDLE)) begin
                buf_q <= {w_buf_base[CODE_LEN-2:0], w_key_code};
                num_q <= (w_num_base == 2'(CODE_LEN)) ? w_num_base : w_num_base + 2'd1;
            end
        end
    end

    always_comb begin
        w_glyph = SEG_BLANK;
        if (state_q != ST_IDLE) begin
            if (dig_q == 3'd7) begin
                w_glyph = (state_q == ST_SET) ? SEG_S : SEG_I;
            end else if ((dig_q < 3'd3) && (dig_q < {1'b0, num_q})) begin
                w_glyph = hex_glyph(buf_q[dig_q[1:0]]);
            end
        end
    end

    // Display digit advances on the same dwell tick as the keypad columns
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dig_q    <= '0;
            led_en_q <= 8'hFF;
            led_cx_q <= 8'hFF;
        end else begin
            if (w_tick) begin
                dig_q <= dig_q + 3'd1;
            end
            led_en_q <= ~(8'b1 << dig_q);
            led_cx_q <= w_glyph;
        end
    end

    assign red_led = red_q;
    assign gre_led = gre_q;
    assign led_en  = led_en_q;
    assign led_cx  = led_cx_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_lock.sv
// ============================================================================
// tb_keypad_lock : directed scoreboard bench for keypad_lock
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_keypad_lock;

    localparam int unsigned THR   = 5;
    localparam int          DWELL = THR + 1;
    localparam int          ROUND = 4 * DWELL;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       set_code_button = 1'b0;
    logic       confirm_button = 1'b0;
    logic       input_button = 1'b0;
    logic [3:0] row;
    logic [3:0] col;
    logic [2:0] red_led;
    logic [2:0] gre_led;
    logic [7:0] led_cx;
    logic [7:0] led_en;

    logic [15:0] keys_down = '0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] exp_keys [$];
    logic [5:0] exp_leds [$];

    keypad_lock #(
        .CNT_THRESHOLD (THR)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .set_code_button (set_code_button),
        .confirm_button  (confirm_button),
        .input_button    (input_button),
        .row             (row),
        .col             (col),
        .red_led         (red_led),
        .gre_led         (gre_led),
        .led_cx          (led_cx),
        .led_en          (led_en)
    );

    always #5 clk = ~clk;

    // Passive matrix: a row reads low when a held key sits in a driven column
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            row[r] = ~|(keys_down[r*4 +: 4] & ~col);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int key_pos(input logic [3:0] k);
        case (k)
            4'h1: return 12;
            4'h2: return 13;
            4'h3: return 14;
            4'hA: return 15;
            4'h4: return 8;
            4'h5: return 9;
            4'h6: return 10;
            4'hB: return 11;
            4'h7: return 4;
            4'h8: return 5;
            4'h9: return 6;
            4'hC: return 7;
            4'hE: return 0;
            4'h0: return 1;
            4'hF: return 2;
            default: return 3;
        endcase
    endfunction

    task automatic press_key(input logic [3:0] k);
        int p;
        p = key_pos(k);
        exp_keys.push_back(k);
        keys_down[p] = 1'b1;
        repeat (3 * ROUND) @(negedge clk);
        keys_down[p] = 1'b0;
        repeat (2 * ROUND) @(negedge clk);
    endtask

    task automatic press_btn(input int b);
        case (b)
            0: set_code_button = 1'b1;
            1: input_button    = 1'b1;
            default: confirm_button = 1'b1;
        endcase
        repeat (3) @(negedge clk);
        set_code_button = 1'b0;
        input_button    = 1'b0;
        confirm_button  = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic confirm_expect(input logic [2:0] g, input logic [2:0] r);
        exp_leds.push_back({g, r});
        press_btn(2);
    endtask

    task automatic enter3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        press_key(a);
        press_key(b);
        press_key(c);
    endtask

    // Key-event monitor
    always @(negedge clk) begin
        if (reset && dut.u_scan.key_valid_o) begin
            if (exp_keys.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL key_event: got unexpected code %0h expected none", dut.u_scan.key_code_o);
            end else begin
                check("key_code", 32'(dut.u_scan.key_code_o), 32'(exp_keys.pop_front()));
            end
        end
    end

    // Result monitor: LEDs settle on the clock edge that sees the confirm edge
    initial begin
        logic [5:0] e;
        forever begin
            @(posedge confirm_button);
            @(posedge clk);
            @(negedge clk);
            if (exp_leds.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL led_result: got gre=%0b red=%0b expected none", gre_led, red_led);
            end else begin
                e = exp_leds.pop_front();
                check("gre_led", 32'(gre_led), 32'(e[5:3]));
                check("red_led", 32'(red_led), 32'(e[2:0]));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;

        repeat (3) @(negedge clk);
        check("rst_col",    32'(col),     32'h0E);
        check("rst_red",    32'(red_led), 32'h0);
        check("rst_gre",    32'(gre_led), 32'h0);
        check("rst_led_en", 32'(led_en),  32'hFF);
        check("rst_led_cx", 32'(led_cx),  32'hFF);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("led_en_digit0", 32'(led_en), 32'hFE);
        check("led_cx_idle",   32'(led_cx), 32'hFF);

        // Set 1,2,3 then unlock with 1,2,3
        press_btn(0);
        guard = 0;
        while (led_en != 8'h7F && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("set_glyph_S", 32'(led_cx), 32'h49);
        enter3(4'h1, 4'h2, 4'h3);
        confirm_expect(3'b000, 3'b000);
        press_btn(1);
        enter3(4'h1, 4'h2, 4'h3);
        confirm_expect(3'b111, 3'b000);

        // Held key gives one event per press; wrong code fails once
        press_btn(1);
        enter3(4'h1, 4'h1, 4'h1);
        confirm_expect(3'b000, 3'b001);

        // Keys 2 and 3 held together starting in column 0 -> events 2 then 3
        press_btn(1);
        press_key(4'h1);
        guard = 0;
        while (col != 4'b1110 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        exp_keys.push_back(4'h2);
        exp_keys.push_back(4'h3);
        keys_down[key_pos(4'h2)] = 1'b1;
        keys_down[key_pos(4'h3)] = 1'b1;
        repeat (3 * ROUND) @(negedge clk);
        keys_down = '0;
        repeat (2 * ROUND) @(negedge clk);
        confirm_expect(3'b111, 3'b000);

        // New code A,B,7 and escalating failures
        press_btn(0);
        enter3(4'hA, 4'hB, 4'h7);
        confirm_expect(3'b000, 3'b000);
        press_btn(1);
        enter3(4'h1, 4'h2, 4'h3);
        confirm_expect(3'b000, 3'b001);
        press_btn(1);
        enter3(4'hA, 4'hB, 4'h1);
        confirm_expect(3'b000, 3'b011);
        press_btn(1);
        enter3(4'hA, 4'hC, 4'h7);
        confirm_expect(3'b000, 3'b111);
        press_btn(1);
        enter3(4'hA, 4'hB, 4'h7);
        confirm_expect(3'b111, 3'b000);

        // Short entries: INPUT fails, SET keeps old code; 4th digit drops oldest
        press_btn(1);
        press_key(4'hA);
        press_key(4'hB);
        confirm_expect(3'b000, 3'b001);
        press_btn(0);
        press_key(4'h4);
        press_key(4'h5);
        confirm_expect(3'b000, 3'b001);
        press_btn(1);
        press_key(4'h5);
        enter3(4'hA, 4'hB, 4'h7);
        confirm_expect(3'b111, 3'b000);

        // Reset mid-entry restores everything including the stored code
        press_btn(0);
        press_key(4'h9);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_col",    32'(col),     32'h0E);
        check("midrst_red",    32'(red_led), 32'h0);
        check("midrst_gre",    32'(gre_led), 32'h0);
        check("midrst_led_en", 32'(led_en),  32'hFF);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        press_btn(1);
        enter3(4'h0, 4'h0, 4'h0);
        confirm_expect(3'b111, 3'b000);

        guard = 0;
        while ((exp_keys.size() != 0 || exp_leds.size() != 0) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("keys_drained", 32'(exp_keys.size()), 32'd0);
        check("leds_drained", 32'(exp_leds.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/keypad_lock.md
Name: keypad_lock

Overview:
- 3-digit combination lock driven by a 4x4 matrix keypad, three push-buttons, an 8-digit multiplexed 7-segment display and two 3-LED status banks.
- Scans keypad columns and detects key presses.
- Supports setting a new code and checking an entered code against it.
- Sits at board top level, between the keypad/buttons and the LEDs/display.

Parameters:
- CNT_THRESHOLD, 100000: column dwell time in clk cycles minus 1; each column and each display digit is active for CNT_THRESHOLD+1 cycles. Benches use 5.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- set_code_button  in  1  active-high; enter SET mode
- confirm_button  in  1  active-high; finish entry
- input_button  in  1  active-high; enter INPUT (unlock attempt) mode
- row  in  4  keypad rows, active-low
- col  out  4  keypad column drive, one-hot active-low
- red_led  out  3  consecutive-failure indicator
- gre_led  out  3  unlock indicator
- led_cx  out  8  segments {a,b,c,d,e,f,g,dp}, active-low
- led_en  out  8  digit enables, one-hot active-low

Behaviour:
- Reset values: col=1110, red_led=000, gre_led=000, led_en=FF, led_cx=FF. Stored code = 0,0,0. Mode=IDLE. Entry buffer empty. Failure count=0.
- Column scan: col rotates 1110→1101→1011→0111→1110. Each value is held CNT_THRESHOLD+1 cycles via a free-running dwell counter.
- row is sampled on the last cycle of each dwell.
- Key map, indexed [row bit][col bit 0..3]:
  - row[3]: 1 2 3 A
  - row[2]: 4 5 6 B
  - row[1]: 7 8 9 C
  - row[0]: E(*) 0 F(#) D
- Key codes are 4-bit hex.
- Press detection:
  - A 16-bit pressed-state register is updated per column sample.
  - A key event fires (1-cycle pulse plus code) on a 0→1 transition of a key's bit.
  - Holding a key gives exactly one event; keys in different columns in one scan round each give an event, in scan order.
  - If several rows in one column are low at once, the event takes the lowest row index.
- Buttons: level inputs, rising-edge detected internally (1-cycle pulse). Priority: set_code > input > confirm.
- FSM states:
  - IDLE
  - SET: entered on set_code edge from any state; clears entry buffer and gre_led.
  - INPUT: entered on input_button edge from any state except SET; clears entry buffer and gre_led.
  - SET + confirm: if 3 digits entered, stored code := buffer; else stored code unchanged. Go to IDLE.
  - INPUT + confirm: success iff count==3 and buffer==stored code.
    - Success: gre_led=111, red_led=000, failure count=0.
    - Failure: failure count saturates at 3; red_led = thermometer (1→001, 2→011, 3→111); gre_led=000.
    - Go to IDLE.
  - Key events in SET or INPUT shift into a 3-digit buffer (newest in digit 0). Count saturates at 3; a 4th digit drops the oldest.
  - Key events in IDLE are ignored. Confirm in IDLE is ignored.
  - A key event and a button edge in the same cycle: the button is processed first, then the key is applied in the new state.
- No lockout: a correct entry after any number of failures still succeeds.
- Display:
  - Digits scanned 0..7, each enabled for CNT_THRESHOLD+1 cycles.
  - Digits 0..2 show entered buffer digits (hex glyphs), blank if not entered or in IDLE.
  - Digit 7 shows 'S' in SET and 'I' in INPUT, blank in IDLE. Other digits blank.
- gre_led/red_led hold their value until the next mode entry (gre) or result (red).
- Reset mid-entry: all state returns to reset values, including the stored code.

Decomposition:
- Shared package: key code constants, FSM state enum, 7-segment glyph table, CODE_LEN=3.
- One natural sub-module: keypad_scan (column drive, dwell counter, press detection, emits key_valid/key_code). FSM, comparison and display stay in the top.

Test Plan:
- Reset, set_code with key 1 (col0,row[3]), then keys 2, 3, confirm; input_button, keys 1,2,3, confirm → gre_led=111, red_led=000.
- Input 1,1,1 (key held across dwell then released each time), confirm → one event per press, buffer 1,1,1, red_led=001, gre_led=000.
- Keys 2 and 3 pressed in consecutive columns of one scan round → two events, order 2 then 3.
- Set A,B,7, confirm. Then input 1,2,3 / A,B,1 / A,C,7, each confirmed → red_led 001, 011, 111. Then A,B,7 → gre_led=111, red_led=000.
- Confirm after only 2 digits in INPUT → failure. In SET → stored code unchanged (old code still unlocks).
- Assert reset mid-entry → col=1110, LEDs off, led_en=FF; afterwards 0,0,0 unlocks.
